// File: rtl/alu_pkg.sv
// Shared ALU definitions: the flag bundle consumed by branch/compare logic and
// the parameter legality check used by the pipelined adder.
package alu_pkg;

    typedef struct packed {
        logic carry;
        logic overflow;
        logic zero;
    } alu_flags_t;

    // stages is tested first so the modulo never sees a zero divisor.
    function automatic bit adder_params_ok(input int width, input int stages);
        if (stages < 1) begin
            return 1'b0;
        end
        return (width >= 2) && (stages <= width) && ((width % stages) == 0);
    endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational SW-bit adder slice: sum, carry out, and the carry into its MSB
// (the latter feeds signed-overflow detection on the top slice).
module adder_slice #(
    parameter int SW = 8
) (
    input  logic [SW-1:0] a_i,
    input  logic [SW-1:0] b_i,
    input  logic          cin_i,
    output logic [SW-1:0] sum_o,
    output logic          cout_o,
    output logic          c_msb_o
);

    logic [SW:0] full;

    assign full    = {1'b0, a_i} + {1'b0, b_i} + {{SW{1'b0}}, cin_i};
    assign sum_o   = full[SW-1:0];
    assign cout_o  = full[SW];
    // Carry into the MSB is recovered from the MSB sum bit, so SW = 1 also works.
    assign c_msb_o = a_i[SW-1] ^ b_i[SW-1] ^ full[SW-1];

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined add/subtract lane: one SW-bit slice per stage with a registered
// carry chain, skewed operand/sum registers and a backpressured handshake.
module pipelined_adder
    import alu_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero
);

    localparam int SW = WIDTH / STAGES;

    if (!adder_params_ok(WIDTH, STAGES)) begin : g_bad_params
        $error("pipelined_adder: need WIDTH >= 2 and WIDTH a multiple of STAGES >= 1");
    end

    // Handshake: an item moves from stage k-1 into stage k on an edge where
    // stage k-1 is valid and stage k is ready; ready_k = !valid_k | ready_k+1,
    // with out_ready closing the chain, so bubbles collapse and a full pipe
    // still advances whenever the consumer takes a result.
    logic [STAGES-1:0] valid_vec;
    logic [STAGES-1:0] ready;
    alu_flags_t        flags_q;

    always_comb begin
        logic acc;
        acc   = out_ready;
        ready = '0;
        for (int i = STAGES - 1; i >= 0; i--) begin
            acc      = acc | ~valid_vec[i];
            ready[i] = acc;
        end
    end

    assign in_ready = ready[0];

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        localparam int LO = i * SW;
        localparam int HI = LO + SW;

        logic              v_in;
        logic              c_in;
        logic [WIDTH-1:LO] a_in;
        logic [WIDTH-1:LO] b_in;
        logic [SW-1:0]     s_slice;
        logic              c_out;
        logic              c_msb;
        logic              valid_q;
        logic [HI-1:0]     sum_q;
        logic [HI-1:0]     sum_d;

        if (i == 0) begin : g_src
            assign v_in  = in_valid;
            assign c_in  = sub;
            assign a_in  = a;
            assign b_in  = sub ? ~b : b;
            assign sum_d = s_slice;
        end else begin : g_src
            assign v_in  = g_stage[i-1].valid_q;
            assign c_in  = g_stage[i-1].g_ops.carry_q;
            assign a_in  = g_stage[i-1].g_ops.a_q;
            assign b_in  = g_stage[i-1].g_ops.b_q;
            assign sum_d = {s_slice, g_stage[i-1].sum_q};
        end

        adder_slice #(
            .SW(SW)
        ) u_slice (
            .a_i    (a_in[HI-1:LO]),
            .b_i    (b_in[HI-1:LO]),
            .cin_i  (c_in),
            .sum_o  (s_slice),
            .cout_o (c_out),
            .c_msb_o(c_msb)
        );

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                valid_q <= 1'b0;
                sum_q   <= '0;
            end else if (ready[i]) begin
                valid_q <= v_in;
                if (v_in) begin
                    sum_q <= sum_d;
                end
            end
        end

        // Only stages with work left ahead carry operand skew and a carry.
        if (i < STAGES - 1) begin : g_ops
            logic [WIDTH-1:HI] a_q;
            logic [WIDTH-1:HI] b_q;
            logic              carry_q;
            logic              c_msb_unused;

            assign c_msb_unused = c_msb;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    a_q     <= '0;
                    b_q     <= '0;
                    carry_q <= 1'b0;
                end else if (ready[i] && v_in) begin
                    a_q     <= a_in[WIDTH-1:HI];
                    b_q     <= b_in[WIDTH-1:HI];
                    carry_q <= c_out;
                end
            end
        end

        assign valid_vec[i] = valid_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags_q <= '0;
        end else if (ready[STAGES-1] && g_stage[STAGES-1].v_in) begin
            flags_q.carry    <= g_stage[STAGES-1].c_out;
            flags_q.overflow <= g_stage[STAGES-1].c_out ^ g_stage[STAGES-1].c_msb;
            flags_q.zero     <= ~|g_stage[STAGES-1].sum_d;
        end
    end

    assign out_valid = valid_vec[STAGES-1];
    assign sum       = g_stage[STAGES-1].sum_q;
    assign carry_out = flags_q.carry;
    assign overflow  = flags_q.overflow;
    assign zero      = flags_q.zero;

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed and randomized checks of pipelined_adder against an arithmetic
// reference model, including backpressure, stall hold and mid-flight reset.
module tb_pipelined_adder;

    localparam int W  = 32;
    localparam int S  = 4;
    localparam int EW = W + 3;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         carry_out;
    logic         overflow;
    logic         zero;

    int compared   = 0;
    int mismatched = 0;

    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] held;
    logic [EW-1:0] mon_obs;
    logic          was_stall = 1'b0;
    int            cyc = 0;
    int            win_fires = 0;
    int            win_first = 0;
    int            win_last = 0;
    int            fill_cnt;

    pipelined_adder #(
        .WIDTH (W),
        .STAGES(S)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .sub      (sub),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .carry_out(carry_out),
        .overflow (overflow),
        .zero     (zero)
    );

    always #5 clk = ~clk;

    // Result packed as {carry, overflow, zero, sum} from plain integer arithmetic.
    function automatic logic [EW-1:0] ref_model(input logic [W-1:0] x, input logic [W-1:0] y,
                                                input logic s);
        logic [W:0]   wide;
        logic [W-1:0] r;
        logic         c;
        logic         v;
        longint       sx;
        longint       sy;
        longint       sr;
        longint       lim;
        sx  = $signed(x);
        sy  = $signed(y);
        lim = longint'(1) <<< (W - 1);
        if (s) begin
            r  = x - y;
            c  = (x >= y);
            sr = sx - sy;
        end else begin
            wide = {1'b0, x} + {1'b0, y};
            r    = wide[W-1:0];
            c    = wide[W];
            sr   = sx + sy;
        end
        v = (sr >= lim) || (sr < -lim);
        return {c, v, (r == '0), r};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        compared++;
        assert (obs === expv)
        else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Scoreboard: pops on output handshakes, pushes on input handshakes, and
    // requires outputs to hold across a stalled cycle.
    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            was_stall = 1'b0;
        end else begin
            mon_obs = {carry_out, overflow, zero, sum};
            if (was_stall) begin
                check("stall_hold", 64'(mon_obs), 64'(held));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", 64'(out_valid), 64'd0);
                end else begin
                    check("result", 64'(mon_obs), 64'(exp_q.pop_front()));
                end
                if (win_fires == 0) begin
                    win_first = cyc;
                end
                win_last = cyc;
                win_fires++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_model(a, b, sub));
            end
            was_stall = out_valid && !out_ready;
            held      = mon_obs;
        end
    end

    task automatic send_one(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                            input logic [EW-1:0] expv, input string tag);
        int lat;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        a         = x;
        b         = y;
        sub       = s;
        @(negedge clk);
        check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = $urandom;
        b        = $urandom;
        sub      = 1'($urandom_range(0, 1));
        lat      = 1;
        @(negedge clk);
        while (!out_valid && lat < 50) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, 64'(lat), 64'(S));
        check({tag, "_value"}, 64'({carry_out, overflow, zero, sum}), 64'(expv));
        @(posedge clk);
        #1;
    endtask

    task automatic drive_random();
        a   = $urandom;
        b   = $urandom;
        sub = 1'($urandom_range(0, 1));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        sub       = 1'b0;

        // Asynchronous reset, observed before any clock edge.
        #2 reset = 1'b1;
        #1;
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_sum", 64'(sum), 64'd0);
        check("reset_flags", 64'({carry_out, overflow, zero}), 64'd0);
        check("reset_in_ready", 64'(in_ready), 64'd1);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        send_one(32'hFFFF_FFFF, 32'h1, 1'b0, {3'b101, 32'h0000_0000}, "carry_chain");
        send_one(32'h0000_00FF, 32'h1, 1'b0, {3'b000, 32'h0000_0100}, "byte_carry");
        send_one(32'h0000_0005, 32'h7, 1'b1, {3'b000, 32'hFFFF_FFFE}, "sub_borrow");
        send_one(32'h8000_0000, 32'h1, 1'b1, {3'b110, 32'h7FFF_FFFF}, "sub_overflow");
        send_one(32'h7FFF_FFFF, 32'h1, 1'b0, {3'b010, 32'h8000_0000}, "add_overflow");
        send_one(32'h0000_0009, 32'h9, 1'b1, {3'b101, 32'h0000_0000}, "sub_zero");

        // Back-to-back stream with the consumer always ready.
        win_fires = 0;
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            in_valid = 1'b1;
            drive_random();
            @(negedge clk);
            check("stream_in_ready", 64'(in_ready), 64'd1);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        for (int k = 0; k < 20 && win_fires < 8; k++) begin
            @(posedge clk);
            #1;
        end
        check("stream_count", 64'(win_fires), 64'd8);
        check("stream_consecutive", 64'(win_last - win_first), 64'd7);

        // Fill under backpressure: exactly S accepts before in_ready falls.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        drive_random();
        fill_cnt = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (!in_ready) break;
            fill_cnt++;
            @(posedge clk);
            #1;
            drive_random();
        end
        @(posedge clk);
        #1;
        check("fill_accepts", 64'(fill_cnt), 64'(S));
        for (int k = 0; k < 3; k++) begin
            drive_random();
            @(negedge clk);
            check("full_in_ready", 64'(in_ready), 64'd0);
            @(posedge clk);
            #1;
        end

        // Accept and retire on the same edge while full.
        out_ready = 1'b1;
        @(negedge clk);
        check("full_pass_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        drive_random();
        @(negedge clk);
        check("full_after_pass", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;

        // Random valid/ready traffic, then drain.
        for (int k = 0; k < 80; k++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            drive_random();
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 30 && (exp_q.size() != 0 || out_valid); k++) begin
            @(posedge clk);
            #1;
        end
        check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
        check("drain_out_valid", 64'(out_valid), 64'd0);

        // Reset with three operations in flight.
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            drive_random();
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("inflight_out_valid", 64'(out_valid), 64'd1);
        #2 reset = 1'b1;
        exp_q.delete();
        #1;
        check("midreset_out_valid", 64'(out_valid), 64'd0);
        check("midreset_sum", 64'(sum), 64'd0);
        check("midreset_flags", 64'({carry_out, overflow, zero}), 64'd0);
        check("midreset_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        #1 reset = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("post_reset_idle", 64'(out_valid), 64'd0);
            @(posedge clk);
            #1;
        end
        send_one(32'h0000_0002, 32'h3, 1'b0, {3'b000, 32'h0000_0005}, "after_reset");
        check("final_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
